filter_biquad_cascade: RTL and testbench

//  N-section cascaded IIR biquad (direct form II) sharing one saturating multiply-accumulate (MAC),

---
 rtl/filter_biquad_cascade_pkg.sv | 28 ++
 rtl/filter_biquad_cascade_if.sv | 31 +++
 rtl/filter_biquad_cascade_mac.sv | 52 +++++
 rtl/filter_biquad_cascade.sv | 167 ++++++++++++++++
 tb/tb_filter_biquad_cascade.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_biquad_cascade_pkg.sv
// Shared encodings for the cascaded biquad: coefficient slots, MAC step sequence, FSM states.
package filter_biquad_cascade_pkg;

  localparam int unsigned CIDX_K     = 0;
  localparam int unsigned CIDX_A1    = 1;
  localparam int unsigned CIDX_A2    = 2;
  localparam int unsigned CIDX_B0    = 3;
  localparam int unsigned CIDX_B1    = 4;
  localparam int unsigned CIDX_B2    = 5;
  localparam int unsigned NUM_COEFS  = 6;

  // Step order matches the coefficient slot order, so a step directly indexes the bank.
  typedef enum logic [2:0] {
    StepK  = 3'd0,
    StepA1 = 3'd1,
    StepA2 = 3'd2,
    StepB0 = 3'd3,
    StepB1 = 3'd4,
    StepB2 = 3'd5
  } step_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/filter_biquad_cascade_if.sv
// Sample, coefficient-write and status signals of the biquad cascade.
interface filter_biquad_cascade_if #(
  parameter int unsigned AUDIO_BDEPTH = 12,
  parameter int unsigned COEF_BDEPTH  = 12,
  parameter int unsigned SEC_BITS     = 2
);
  logic signed [AUDIO_BDEPTH-1:0] audio_in;
  logic                           valid_in;
  logic signed [AUDIO_BDEPTH-1:0] audio_out;
  logic                           valid_out;
  logic                           busy;
  logic                           coef_wr;
  logic [SEC_BITS-1:0]            coef_sec;
  logic [2:0]                     coef_idx;
  logic signed [COEF_BDEPTH-1:0]  coef_data;
  logic                           coef_ready;
  logic                           sat_clear;
  logic                           sat_mult;
  logic                           sat_accum;
  logic                           overrun;

  modport master (
    output audio_in, valid_in, coef_wr, coef_sec, coef_idx, coef_data, sat_clear,
    input  audio_out, valid_out, busy, coef_ready, sat_mult, sat_accum, overrun
  );

  modport slave (
    input  audio_in, valid_in, coef_wr, coef_sec, coef_idx, coef_data, sat_clear,
    output audio_out, valid_out, busy, coef_ready, sat_mult, sat_accum, overrun
  );
endinterface

// File: rtl/filter_biquad_cascade_mac.sv
// Shared saturating multiply-accumulate: operand select per step, Q2 product scaling, clamped add.
module filter_biquad_cascade_mac
  import filter_biquad_cascade_pkg::*;
#(
  parameter int unsigned AUDIO_BDEPTH = 12,
  parameter int unsigned COEF_BDEPTH  = 12,
  parameter int unsigned COEF_FRAC    = COEF_BDEPTH - 2
) (
  input  step_e                          step_i,
  input  logic signed [AUDIO_BDEPTH-1:0] acc_i,
  input  logic signed [AUDIO_BDEPTH-1:0] z1_i,
  input  logic signed [AUDIO_BDEPTH-1:0] z2_i,
  input  logic signed [AUDIO_BDEPTH-1:0] zsave_i,
  input  logic signed [COEF_BDEPTH-1:0]  coef_i,
  output logic signed [AUDIO_BDEPTH-1:0] result_o,
  output logic                           sat_mult_o,
  output logic                           sat_accum_o
);
  localparam int unsigned PW = AUDIO_BDEPTH + COEF_BDEPTH;
  localparam logic signed [AUDIO_BDEPTH-1:0] SatMax = {1'b0, {(AUDIO_BDEPTH-1){1'b1}}};
  localparam logic signed [AUDIO_BDEPTH-1:0] SatMin = {1'b1, {(AUDIO_BDEPTH-1){1'b0}}};

  logic signed [AUDIO_BDEPTH-1:0] data, addend, prod;
  logic signed [PW-1:0]           prod_full, prod_shift;
  logic signed [AUDIO_BDEPTH:0]   sum;

  always_comb begin
    data   = acc_i;
    addend = acc_i;
    unique case (step_i)
      StepK, StepB0: addend = '0;
      StepA1:        data = z1_i;
      StepA2:        data = z2_i;
      StepB1:        data = z2_i;  // z2 already holds the pre-update z1
      StepB2:        data = zsave_i;
      default: ;
    endcase
  end

  always_comb begin
    prod_full  = PW'(data) * PW'(coef_i);
    prod_shift = prod_full >>> COEF_FRAC;
    sat_mult_o = prod_shift[PW-1:AUDIO_BDEPTH-1] != {(PW-AUDIO_BDEPTH+1){prod_shift[PW-1]}};
    if (sat_mult_o) prod = prod_shift[PW-1] ? SatMin : SatMax;
    else            prod = prod_shift[AUDIO_BDEPTH-1:0];
    sum         = (AUDIO_BDEPTH+1)'(addend) + (AUDIO_BDEPTH+1)'(prod);
    sat_accum_o = sum[AUDIO_BDEPTH] != sum[AUDIO_BDEPTH-1];
    if (sat_accum_o) result_o = sum[AUDIO_BDEPTH] ? SatMin : SatMax;
    else             result_o = sum[AUDIO_BDEPTH-1:0];
  end

endmodule

// File: rtl/filter_biquad_cascade.sv
// N-section direct-form-II biquad cascade time-multiplexed over one saturating MAC,
// with a runtime coefficient bank, one-entry pending write and sticky status flags.
module filter_biquad_cascade
  import filter_biquad_cascade_pkg::*;
#(
  parameter int unsigned AUDIO_BDEPTH = 12,
  parameter int unsigned COEF_BDEPTH  = 12,
  parameter int unsigned COEF_FRAC    = COEF_BDEPTH - 2,
  parameter int unsigned NUM_SECTIONS = 4,
  parameter int unsigned SEC_BITS     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
  input logic                  clk,
  input logic                  rst_n,
  filter_biquad_cascade_if.slave bus
);
  localparam logic signed [COEF_BDEPTH-1:0] CoefOne = COEF_BDEPTH'(2 ** COEF_FRAC);
  localparam logic [SEC_BITS:0]   SecCount = (SEC_BITS+1)'(NUM_SECTIONS);
  localparam logic [SEC_BITS-1:0] SecLast  = SEC_BITS'(NUM_SECTIONS - 1);

  state_e                         state_q, state_d;
  step_e                          step_q;
  logic [SEC_BITS-1:0]            sec_q;
  logic                           valid_in_q, start, busy, mac_en;
  logic signed [AUDIO_BDEPTH-1:0] acc_q, zsave_q, audio_out_q, mac_result;
  logic signed [AUDIO_BDEPTH-1:0] z1_q [NUM_SECTIONS];
  logic signed [AUDIO_BDEPTH-1:0] z2_q [NUM_SECTIONS];
  logic signed [COEF_BDEPTH-1:0]  coef_q [NUM_SECTIONS][NUM_COEFS];
  logic                           valid_out_q, mac_sat_mult, mac_sat_accum;
  logic                           sat_mult_q, sat_accum_q, overrun_q;
  logic                           pend_valid_q, wr_ok, wr_take;
  logic [SEC_BITS-1:0]            pend_sec_q;
  logic [2:0]                     pend_idx_q;
  logic signed [COEF_BDEPTH-1:0]  pend_data_q;

  assign start   = bus.valid_in & ~valid_in_q;
  assign wr_ok   = (bus.coef_idx <= 3'(CIDX_B2)) && ({1'b0, bus.coef_sec} < SecCount);
  assign wr_take = bus.coef_wr & ~pend_valid_q & wr_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StMac;
      StMac:   if (step_q == StepB2 && sec_q == SecLast) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = state_q != StIdle;
    mac_en         = state_q == StMac;
    bus.busy       = busy;
    bus.coef_ready = ~pend_valid_q;
    bus.audio_out  = audio_out_q;
    bus.valid_out  = valid_out_q;
    bus.sat_mult   = sat_mult_q;
    bus.sat_accum  = sat_accum_q;
    bus.overrun    = overrun_q;
  end

  filter_biquad_cascade_mac #(
    .AUDIO_BDEPTH (AUDIO_BDEPTH),
    .COEF_BDEPTH  (COEF_BDEPTH),
    .COEF_FRAC    (COEF_FRAC)
  ) u_mac (
    .step_i      (step_q),
    .acc_i       (acc_q),
    .z1_i        (z1_q[sec_q]),
    .z2_i        (z2_q[sec_q]),
    .zsave_i     (zsave_q),
    .coef_i      (coef_q[sec_q][step_q]),
    .result_o    (mac_result),
    .sat_mult_o  (mac_sat_mult),
    .sat_accum_o (mac_sat_accum)
  );

  // The start cycle loads the sample into acc, so every section's first step multiplies acc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_in_q  <= 1'b0;
      valid_out_q <= 1'b0;
      audio_out_q <= '0;
      acc_q       <= '0;
      zsave_q     <= '0;
      sec_q       <= '0;
      step_q      <= StepK;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        z1_q[s] <= '0;
        z2_q[s] <= '0;
      end
    end else begin
      valid_in_q  <= bus.valid_in;
      valid_out_q <= 1'b0;
      unique case (state_q)
        StIdle: if (start) begin
          acc_q  <= bus.audio_in;
          sec_q  <= '0;
          step_q <= StepK;
        end
        StMac: begin
          acc_q <= mac_result;
          if (step_q == StepB0) begin
            z1_q[sec_q] <= acc_q;
            z2_q[sec_q] <= z1_q[sec_q];
            zsave_q     <= z2_q[sec_q];
          end
          if (step_q == StepB2) begin
            step_q <= StepK;
            sec_q  <= sec_q + SEC_BITS'(1);
          end else begin
            step_q <= step_e'(step_q + 3'd1);
          end
        end
        StOut: begin
          audio_out_q <= acc_q;
          valid_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A pending write lands in the first idle cycle, ahead of any start sampled in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_sec_q   <= '0;
      pend_idx_q   <= '0;
      pend_data_q  <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        for (int c = 0; c < NUM_COEFS; c++) begin
          coef_q[s][c] <= (c == CIDX_K || c == CIDX_B0) ? CoefOne : '0;
        end
      end
    end else if (state_q == StIdle && pend_valid_q) begin
      coef_q[pend_sec_q][pend_idx_q] <= pend_data_q;
      pend_valid_q                   <= 1'b0;
    end else if (wr_take) begin
      if (state_q == StIdle) begin
        coef_q[bus.coef_sec][bus.coef_idx] <= bus.coef_data;
      end else begin
        pend_valid_q <= 1'b1;
        pend_sec_q   <= bus.coef_sec;
        pend_idx_q   <= bus.coef_idx;
        pend_data_q  <= bus.coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_mult_q  <= 1'b0;
      sat_accum_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sat_mult_q  <= (mac_en & mac_sat_mult) | (sat_mult_q & ~bus.sat_clear);
      sat_accum_q <= (mac_en & mac_sat_accum) | (sat_accum_q & ~bus.sat_clear);
      overrun_q   <= (start & busy) | (overrun_q & ~bus.sat_clear);
    end
  end

endmodule

// File: tb/tb_filter_biquad_cascade.sv
// Directed bench for the biquad cascade: reset, latency, feedback, saturation, overrun,
// write-while-busy and mid-computation reset.
module tb_filter_biquad_cascade;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 12;
  localparam int unsigned NS = 4;
  localparam int unsigned SB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  filter_biquad_cascade_if #(.AUDIO_BDEPTH(AW), .COEF_BDEPTH(CW), .SEC_BITS(SB)) bus ();

  filter_biquad_cascade #(
    .AUDIO_BDEPTH (AW),
    .COEF_BDEPTH  (CW),
    .COEF_FRAC    (CW - 2),
    .NUM_SECTIONS (NS),
    .SEC_BITS     (SB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [SB-1:0] sec, input logic [2:0] idx,
                            input logic signed [CW-1:0] data);
    @(negedge clk);
    bus.coef_wr = 1'b1; bus.coef_sec = sec; bus.coef_idx = idx; bus.coef_data = data;
    @(negedge clk);
    bus.coef_wr = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); bus.sat_clear = 1'b1;
    @(negedge clk); bus.sat_clear = 1'b0;
  endtask

  // Raises valid_in and returns the first output and its edge count (-1 if none in 60 edges).
  task automatic run_sample(input logic signed [AW-1:0] s, output logic signed [AW-1:0] res,
                            output int lat);
    @(negedge clk);
    bus.audio_in = s; bus.valid_in = 1'b1;
    lat = -1; res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.valid_out) begin lat = n; res = bus.audio_out; break; end
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.audio_in = '0; bus.valid_in = 1'b0; bus.coef_wr = 1'b0; bus.coef_sec = '0;
    bus.coef_idx = '0; bus.coef_data = '0; bus.sat_clear = 1'b0;
    do_reset();
    checks++; if (bus.audio_out !== 12'sd0) begin errors++;
      $display("FAIL reset_audio_out: got %0d want 0", bus.audio_out); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++;
      $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.coef_ready !== 1'b1) begin errors++;
      $display("FAIL reset_coef_ready: got %b want 1", bus.coef_ready); end
    checks++; if (bus.sat_mult !== 1'b0) begin errors++;
      $display("FAIL reset_sat_mult: got %b want 0", bus.sat_mult); end
    checks++; if (bus.sat_accum !== 1'b0) begin errors++;
      $display("FAIL reset_sat_accum: got %b want 0", bus.sat_accum); end
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_identity();
    logic signed [AW-1:0] res;
    int lat;
    run_sample(12'sd500, res, lat);
    checks++; if (lat !== 26) begin errors++;
      $display("FAIL identity_latency: got %0d want 26", lat); end
    checks++; if (res !== 12'sd500) begin errors++;
      $display("FAIL identity_out: got %0d want 500", res); end
    @(posedge clk); #1;
    checks++; if (bus.valid_out !== 1'b0) begin errors++;
      $display("FAIL identity_pulse_width: got %b want 0", bus.valid_out); end
    checks++; if (bus.audio_out !== 12'sd500) begin errors++;
      $display("FAIL identity_hold: got %0d want 500", bus.audio_out); end
  endtask

  task automatic test_feedback();
    logic signed [AW-1:0] res;
    logic signed [AW-1:0] xin [5] = '{12'sd400, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
    logic signed [AW-1:0] exp [5] = '{12'sd400, 12'sd200, 12'sd100, 12'sd50, 12'sd25};
    int lat;
    do_reset();
    write_coef(2'd0, 3'd1, 12'sd512);
    for (int i = 0; i < 5; i++) begin
      run_sample(xin[i], res, lat);
      checks++; if (res !== exp[i] || lat !== 26) begin errors++;
        $display("FAIL feedback_%0d: got %0d (lat %0d) want %0d (lat 26)", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [AW-1:0] res;
    int lat;
    do_reset();
    write_coef(2'd0, 3'd0, 12'sd2047);
    run_sample(12'sd2000, res, lat);
    checks++; if (res !== 12'sd2047) begin errors++;
      $display("FAIL sat_pos_out: got %0d want 2047", res); end
    checks++; if (bus.sat_mult !== 1'b1 || bus.sat_accum !== 1'b0) begin errors++;
      $display("FAIL sat_pos_flags: got mult=%b accum=%b want 1 0", bus.sat_mult, bus.sat_accum);
    end
    pulse_clear();
    checks++; if (bus.sat_mult !== 1'b0) begin errors++;
      $display("FAIL sat_clear: got %b want 0", bus.sat_mult); end
    run_sample(-12'sd2000, res, lat);
    checks++; if (res !== -12'sd2048) begin errors++;
      $display("FAIL sat_neg_out: got %0d want -2048", res); end
    checks++; if (bus.sat_mult !== 1'b1) begin errors++;
      $display("FAIL sat_neg_flag: got %b want 1", bus.sat_mult); end
    do_reset();
    write_coef(2'd0, 3'd1, 12'sd1024);
    run_sample(12'sd1500, res, lat);
    checks++; if (res !== 12'sd1500 || bus.sat_accum !== 1'b0) begin errors++;
      $display("FAIL accum_first: got %0d accum=%b want 1500 0", res, bus.sat_accum); end
    run_sample(12'sd1500, res, lat);
    checks++; if (res !== 12'sd2047 || bus.sat_accum !== 1'b1) begin errors++;
      $display("FAIL accum_sat: got %0d accum=%b want 2047 1", res, bus.sat_accum); end
  endtask

  task automatic test_overrun();
    logic signed [AW-1:0] res = '0;
    int lat = -1;
    int cnt = 0;
    do_reset();
    @(negedge clk);
    bus.audio_in = 12'sd500; bus.valid_in = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1 || n == 25) begin
        checks++; if (bus.busy !== 1'b1) begin errors++;
          $display("FAIL overrun_busy_%0d: got %b want 1", n, bus.busy); end
      end
      if (n == 26) begin
        checks++; if (bus.busy !== 1'b0) begin errors++;
          $display("FAIL overrun_busy_done: got %b want 0", bus.busy); end
      end
      if (bus.valid_out) begin cnt++; if (lat < 0) lat = n; res = bus.audio_out; end
      @(negedge clk);
      if (n == 4) bus.valid_in = 1'b0;
      if (n == 9) begin bus.valid_in = 1'b1; bus.audio_in = 12'sd100; end
    end
    checks++; if (cnt !== 1 || lat !== 26) begin errors++;
      $display("FAIL overrun_pulses: got %0d at %0d want 1 at 26", cnt, lat); end
    checks++; if (res !== 12'sd500) begin errors++;
      $display("FAIL overrun_out: got %0d want 500", res); end
    checks++; if (bus.overrun !== 1'b1) begin errors++;
      $display("FAIL overrun_flag: got %b want 1", bus.overrun); end
    bus.valid_in = 1'b0;
    pulse_clear();
    checks++; if (bus.overrun !== 1'b0) begin errors++;
      $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
  endtask

  task automatic test_write_busy();
    logic signed [AW-1:0] res = '0;
    int lat = -1;
    do_reset();
    @(negedge clk);
    bus.audio_in = 12'sd500; bus.valid_in = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 5 || n == 20) begin
        checks++; if (bus.coef_ready !== 1'b0) begin errors++;
          $display("FAIL wbusy_ready_low_%0d: got %b want 0", n, bus.coef_ready); end
      end
      if (n == 28) begin
        checks++; if (bus.coef_ready !== 1'b1) begin errors++;
          $display("FAIL wbusy_ready_back: got %b want 1", bus.coef_ready); end
      end
      if (bus.valid_out && lat < 0) begin lat = n; res = bus.audio_out; end
      @(negedge clk);
      if (n == 4) begin
        bus.coef_wr = 1'b1; bus.coef_sec = 2'd1; bus.coef_idx = 3'd3; bus.coef_data = 12'sd512;
      end
      if (n == 5) bus.coef_wr = 1'b0;
    end
    bus.valid_in = 1'b0;
    checks++; if (res !== 12'sd500 || lat !== 26) begin errors++;
      $display("FAIL wbusy_old_coef: got %0d (lat %0d) want 500 (lat 26)", res, lat); end
    run_sample(12'sd500, res, lat);
    checks++; if (res !== 12'sd250) begin errors++;
      $display("FAIL wbusy_new_coef: got %0d want 250", res); end
  endtask

  task automatic test_reset_midop();
    logic signed [AW-1:0] res;
    int lat;
    int cnt = 0;
    do_reset();
    write_coef(2'd0, 3'd0, 12'sd512);
    @(negedge clk);
    bus.audio_in = 12'sd300; bus.valid_in = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.valid_out) cnt++;
      @(negedge clk);
      if (n == 11) begin rst_n = 1'b0; bus.valid_in = 1'b0; end
      if (n == 15) rst_n = 1'b1;
    end
    checks++; if (cnt !== 0) begin errors++;
      $display("FAIL midop_no_output: got %0d pulses want 0", cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL midop_busy: got %b want 0", bus.busy); end
    run_sample(12'sd300, res, lat);
    checks++; if (res !== 12'sd300 || lat !== 26) begin errors++;
      $display("FAIL midop_restart: got %0d (lat %0d) want 300 (lat 26)", res, lat); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_feedback();
    test_saturation();
    test_overrun();
    test_write_busy();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
